// File: rtl/lsu_request.sv
// lsu_request: issues one load/store at a time from the execute stage to a
// request/grant memory port and forwards load sideband to the reader stage.
// Optional response timeout is compiled in with `define LSU_TIMEOUT_EN; without
// it WAIT_RSP waits indefinitely and fault_timeout is tied low.
module lsu_request #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_store,
    input  logic [2:0]  op_f3,
    input  logic [63:0] op_addr,
    input  logic [63:0] op_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic        mem_rvalid,
    output logic [7:0]  rd_be_mask,
    output logic [2:0]  rd_f3,
    output logic        rd_is_load_64,
    output logic        rd_valid,
    output logic        misalign,
    output logic        fault_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp
    } state_e;

    state_e      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic [7:0]  mem_be_q;
    logic [7:0]  rd_be_mask_q;
    logic [2:0]  rd_f3_q;
    logic        rd_ld64_q;
    logic        misalign_q;

    logic [2:0]  byte_off;
    logic        op_aligned;
    logic        op_legal;
    logic        op_ok;
    logic [7:0]  be_base;
    logic [7:0]  be_shifted;
    logic [63:0] wdata_shifted;
    logic        timeout_hit;
    logic        release_op;

    assign byte_off = op_addr[2:0];

    // Decode access size into alignment check and unshifted byte-enable pattern
    always_comb begin
        be_base    = 8'h00;
        op_aligned = 1'b0;
        unique case (op_f3[1:0])
            2'b00: begin
                be_base    = 8'h01;
                op_aligned = 1'b1;
            end
            2'b01: begin
                be_base    = 8'h03;
                op_aligned = ~byte_off[0];
            end
            2'b10: begin
                be_base    = 8'h0F;
                op_aligned = (byte_off[1:0] == 2'b00);
            end
            2'b11: begin
                be_base    = 8'hFF;
                op_aligned = (byte_off == 3'b000);
            end
        endcase
        // Unsigned stores do not exist, and f3=111 has no defined size
        op_legal = !(op_is_store && op_f3[2]) && (op_f3 != 3'b111);
    end

    assign op_ok         = op_aligned && op_legal;
    assign be_shifted    = be_base << byte_off;
    assign wdata_shifted = op_wdata << {byte_off, 3'b000};

`ifdef LSU_TIMEOUT_EN
    logic [31:0] wait_cnt_q;
    logic        fault_q;

    assign timeout_hit   = (wait_cnt_q == 32'(TIMEOUT_CYC - 1));
    assign fault_timeout = fault_q;
`else
    logic unused_timeout_cyc;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign fault_timeout      = 1'b0;
`endif

    // Response (or timeout) ends the transaction; rvalid takes priority over timeout
    assign release_op = (state_q == StWaitRsp) && (mem_rvalid || timeout_hit);

    // Request FSM with registered memory-side and sideband outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
            mem_be_q     <= 8'd0;
            rd_be_mask_q <= 8'd0;
            rd_f3_q      <= 3'd0;
            rd_ld64_q    <= 1'b0;
            misalign_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= 32'd0;
            fault_q      <= 1'b0;
`endif
        end else begin
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            fault_q    <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        if (op_ok) begin
                            state_q      <= StReq;
                            mem_req_q    <= 1'b1;
                            mem_we_q     <= op_is_store;
                            mem_addr_q   <= {op_addr[63:3], 3'b000};
                            mem_wdata_q  <= op_is_store ? wdata_shifted : 64'd0;
                            mem_be_q     <= be_shifted;
                            rd_be_mask_q <= be_shifted;
                            rd_f3_q      <= op_f3;
                            rd_ld64_q    <= !op_is_store && (op_f3 == 3'b011);
                        end else begin
                            // Rejected op never reaches memory; only the pulse is visible
                            misalign_q <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        state_q   <= StWaitRsp;
                        mem_req_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_q <= 32'd0;
`endif
                    end
                end
                StWaitRsp: begin
                    if (release_op) begin
                        state_q      <= StIdle;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= 64'd0;
                        mem_wdata_q  <= 64'd0;
                        mem_be_q     <= 8'd0;
                        rd_be_mask_q <= 8'd0;
                        rd_f3_q      <= 3'd0;
                        rd_ld64_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        fault_q      <= !mem_rvalid;
`endif
                    end
`ifdef LSU_TIMEOUT_EN
                    else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign op_ready      = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign rd_be_mask    = rd_be_mask_q;
    assign rd_f3         = rd_f3_q;
    assign rd_is_load_64 = rd_ld64_q;
    assign misalign      = misalign_q;
    // Load data strobe follows the response directly; stores never raise it
    assign rd_valid      = (state_q == StWaitRsp) && mem_rvalid && !mem_we_q;

endmodule

// File: tb/tb_lsu_request.sv
// Scoreboard bench for lsu_request: the driver pushes expected events computed
// from access-size arithmetic; a negedge monitor pops and compares them.
module tb_lsu_request;

    localparam int unsigned TimeoutCyc = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic        op_is_store = 1'b0;
    logic [2:0]  op_f3 = 3'd0;
    logic [63:0] op_addr = 64'd0;
    logic [63:0] op_wdata = 64'd0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  rd_be_mask;
    logic [2:0]  rd_f3;
    logic        rd_is_load_64;
    logic        rd_valid;
    logic        misalign;
    logic        fault_timeout;
    logic        busy;

    always #5 clk = ~clk;

    lsu_request #(.TIMEOUT_CYC(TimeoutCyc)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_is_store(op_is_store), .op_f3(op_f3), .op_addr(op_addr), .op_wdata(op_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid),
        .rd_be_mask(rd_be_mask), .rd_f3(rd_f3), .rd_is_load_64(rd_is_load_64),
        .rd_valid(rd_valid), .misalign(misalign), .fault_timeout(fault_timeout), .busy(busy)
    );

    typedef enum int {KMis, KGnt, KRd, KTo} kind_e;
    typedef struct {
        kind_e       kind;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [2:0]  f3;
        logic        ld64;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic pop_expect(input kind_e k, input string name, output exp_t e, output bit got);
        n_checks++;
        got = 1'b0;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: got unexpected %s event, expected none", name, k.name());
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k) begin
                n_errors++;
                $display("FAIL %s: got %s event, expected %s", name, k.name(), e.kind.name());
            end else begin
                got = 1'b1;
            end
        end
    endtask

    // Reference: size = 2^f3[1:0] bytes, aligned iff addr is a multiple of size
    function automatic bit model(input bit st, input bit [2:0] f3, input bit [63:0] addr,
                                 input bit [63:0] wdata);
        exp_t        e;
        int unsigned size;
        int unsigned off;
        bit          ok;
        size = 32'd1 << f3[1:0];
        off  = 32'(addr % 64'd8);
        ok   = ((addr % 64'(size)) == 64'd0) && !(st && f3[2]) && (f3 != 3'd7);
        e.we    = st;
        e.addr  = addr - 64'(off);
        e.wdata = st ? (wdata << (8 * off)) : 64'd0;
        e.be    = 8'(((32'd1 << size) - 32'd1) << off);
        e.f3    = f3;
        e.ld64  = !st && (f3 == 3'd3);
        if (!ok) begin
            e.kind = KMis;
            exp_q.push_back(e);
        end else begin
            e.kind = KGnt;
            exp_q.push_back(e);
            if (!st) begin
                e.kind = KRd;
                exp_q.push_back(e);
            end
        end
        return ok;
    endfunction

    // Monitor: pops one expected event per DUT-visible event, checks stall stability
    exp_t        mon_e;
    bit          mon_got;
    logic        pv_pend = 1'b0;
    logic        pv_we = 1'b0;
    logic [63:0] pv_addr = 64'd0;
    logic [63:0] pv_wdata = 64'd0;
    logic [7:0]  pv_be = 8'd0;

    always @(negedge clk) begin
        if (!rst) begin
            pv_pend <= 1'b0;
        end else begin
            if (pv_pend) begin
                check("stall_req", 64'(mem_req), 64'(1));
                check("stall_addr", mem_addr, pv_addr);
                check("stall_wdata", mem_wdata, pv_wdata);
                check("stall_we_be", 64'({mem_we, mem_be}), 64'({pv_we, pv_be}));
            end
            if (misalign) pop_expect(KMis, "misalign_evt", mon_e, mon_got);
            if (mem_req && mem_gnt) begin
                pop_expect(KGnt, "grant_evt", mon_e, mon_got);
                if (mon_got) begin
                    check("gnt_we", 64'(mem_we), 64'(mon_e.we));
                    check("gnt_addr", mem_addr, mon_e.addr);
                    check("gnt_wdata", mem_wdata, mon_e.wdata);
                    check("gnt_be", 64'(mem_be), 64'(mon_e.be));
                    check("gnt_sideband", 64'({rd_be_mask, rd_f3, rd_is_load_64}),
                          64'({mon_e.be, mon_e.f3, mon_e.ld64}));
                end
            end
            if (rd_valid) begin
                pop_expect(KRd, "rd_valid_evt", mon_e, mon_got);
                if (mon_got) begin
                    check("rd_sideband", 64'({rd_be_mask, rd_f3, rd_is_load_64}),
                          64'({mon_e.be, mon_e.f3, mon_e.ld64}));
                end
            end
            if (fault_timeout) pop_expect(KTo, "timeout_evt", mon_e, mon_got);
            pv_pend  <= mem_req && !mem_gnt;
            pv_we    <= mem_we;
            pv_addr  <= mem_addr;
            pv_wdata <= mem_wdata;
            pv_be    <= mem_be;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        op_valid   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_addr"}, mem_addr, 64'd0);
        check({name, "_wdata"}, mem_wdata, 64'd0);
        check({name, "_ctl"}, 64'({op_ready, busy, mem_req, mem_we, mem_be, rd_be_mask, rd_f3,
                                   rd_is_load_64, rd_valid, misalign, fault_timeout}),
              64'({1'b1, 26'd0}));
    endtask

    task automatic send_op(input bit st, input bit [2:0] f3, input bit [63:0] addr,
                           input bit [63:0] wdata, output bit ok);
        int n = 0;
        while (!op_ready && n < 20) begin
            tick();
            n++;
        end
        if (!op_ready) begin
            check("op_ready_wait", 64'(op_ready), 64'(1));
            do_reset();
        end
        ok          = model(st, f3, addr, wdata);
        op_valid    = 1'b1;
        op_is_store = st;
        op_f3       = f3;
        op_addr     = addr;
        op_wdata    = wdata;
        tick();
        op_valid    = 1'b0;
        op_is_store = 1'($urandom);
        op_f3       = 3'($urandom);
        op_addr     = {$urandom, $urandom};
        op_wdata    = {$urandom, $urandom};
        #1;
        if (ok) check("accept_to_req", 64'({mem_req, busy, op_ready, misalign}), 64'(4'b1100));
        else    check("misalign_pulse", 64'({misalign, mem_req, busy, op_ready}), 64'(4'b1001));
    endtask

    task automatic grant(input int dly);
        for (int i = 0; i < dly; i++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'($urandom);
            tick();
            check("req_held", 64'({mem_req, busy, op_ready}), 64'(3'b110));
        end
        mem_gnt    = 1'b1;
        mem_rvalid = 1'($urandom);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check("gnt_to_wait", 64'({mem_req, busy, op_ready}), 64'(3'b010));
    endtask

    task automatic respond(input int dly, input bit st);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("wait_hold", 64'({busy, rd_valid}), 64'(2'b10));
        end
        mem_rvalid = 1'b1;
        #1;
        check("rd_valid_cycle", 64'(rd_valid), 64'(!st));
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("idle_after_rsp", 64'({op_ready, busy, rd_valid}), 64'(3'b100));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit st;
        do_reset();
        check_reset_vals("reset");

        // LB at 0x1003, immediate grant and response: best-case latency
        send_op(1'b0, 3'b000, 64'h1003, 64'h0, ok);
        check("lb_addr", mem_addr, 64'h1000);
        check("lb_be", 64'(mem_be), 64'(8'h08));
        grant(0);
        respond(0, 1'b0);

        // SW at 0x2004
        send_op(1'b1, 3'b010, 64'h2004, 64'hDEADBEEF, ok);
        check("sw_wdata", mem_wdata, 64'hDEADBEEF00000000);
        check("sw_we_be", 64'({mem_we, mem_be}), 64'({1'b1, 8'hF0}));
        grant(0);
        respond(0, 1'b1);

        // Misaligned LD, then illegal unsigned store
        send_op(1'b0, 3'b011, 64'h3004, 64'h0, ok);
        tick();
        check("ld_misalign_1cyc", 64'({misalign, op_ready, mem_req}), 64'(3'b010));
        send_op(1'b1, 3'b101, 64'h0010, 64'h1234, ok);
        tick();
        check("sh_illegal_1cyc", 64'({misalign, op_ready, mem_req}), 64'(3'b010));

        // LW with grant withheld for 5 cycles
        send_op(1'b0, 3'b010, 64'h5008, 64'h0, ok);
        grant(5);
        respond(1, 1'b0);

        // Reset while waiting for the response, then a late rvalid
        send_op(1'b0, 3'b010, 64'h6000, 64'h0, ok);
        grant(0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b1;
        #1;
        check_reset_vals("rst_wait");
        mem_rvalid = 1'b1;
        #1;
        check("late_rvalid", 64'({rd_valid, busy, op_ready}), 64'(3'b001));
        tick();
        mem_rvalid = 1'b0;
        #1;
        check_reset_vals("after_late_rvalid");

        // No response at all
        send_op(1'b0, 3'b011, 64'h7000, 64'h0, ok);
`ifdef LSU_TIMEOUT_EN
        begin : blk_timeout
            exp_t e;
            e = exp_q.pop_back();
            e.kind = KTo;
            exp_q.push_back(e);
            grant(0);
            for (int i = 0; i < int'(TimeoutCyc) - 1; i++) begin
                tick();
                check("to_wait_busy", 64'({busy, fault_timeout}), 64'(2'b10));
            end
            tick();
            check("to_fault", 64'({busy, fault_timeout, op_ready, rd_valid}), 64'(4'b0110));
            tick();
            check("to_pulse_end", 64'({fault_timeout, op_ready}), 64'(2'b01));
        end
`else
        begin : blk_hang
            int busy_low;
            busy_low = 0;
            grant(0);
            for (int i = 0; i < 300; i++) begin
                tick();
                if (!busy || fault_timeout) busy_low++;
            end
            check("wait_indefinite", 64'(busy_low), 64'(0));
            do_reset();
            check_reset_vals("hang_reset");
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            bit [63:0] a;
            bit [2:0]  f;
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
            f  = 3'($urandom);
            st = 1'($urandom);
            send_op(st, f, a, {$urandom, $urandom}, ok);
            if (ok) begin
                grant($urandom_range(0, 3));
                respond($urandom_range(0, 3), st);
            end else if ($urandom_range(0, 1) == 1) begin
                mem_rvalid = 1'b1;
                tick();
                mem_rvalid = 1'b0;
            end
        end

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
